// File: rtl/pipe_seg_reg_hs.sv
// pipe_seg_reg_hs: elastic pipeline segment register with a valid/ready
// handshake and a 2-entry skid buffer (main entry M, skid entry S).
// It carries an opaque payload and supports stall, flush and bubble insertion.
// in_ready is derived only from registered state plus stall/flush, so there is
// no combinational path from out_ready to in_ready.
// Optional feature macro: SEG_PERF_CNT_EN. When it is defined, saturating
// stall/flush/transfer counters are built. Otherwise the three counter
// outputs are tied to zero.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | M invalid, S invalid (M.data = NOP_VAL)
// ONE   | M valid, S invalid
// FULL  | M valid, S valid (S holds the younger payload)
module pipe_seg_reg_hs #(
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   NOP_VAL = '0,
  parameter int              CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [DW-1:0] s_data_q, s_data_d;
  logic          m_valid, s_valid;
  logic          acc, pop;

  // State and payload registers; reset leaves both entries empty and holding bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      m_data_q <= NOP_VAL;
      s_data_q <= NOP_VAL;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
    end
  end

  // Next-state and payload movement. Flush overrides everything else, and
  // stall needs no term here because it already masks acc and pop.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (flush) begin
      state_d  = EMPTY;
      m_data_d = NOP_VAL;
      s_data_d = NOP_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d  = ONE;
            m_data_d = in_data;
          end
        end
        ONE: begin
          if (acc && pop) begin
            m_data_d = in_data;
          end else if (acc) begin
            state_d  = FULL;
            s_data_d = in_data;
          end else if (pop) begin
            state_d  = EMPTY;
            m_data_d = NOP_VAL;
          end
        end
        FULL: begin
          if (pop) begin
            state_d  = ONE;
            m_data_d = s_data_q;
            s_data_d = NOP_VAL;
          end
        end
        default: begin
          state_d  = EMPTY;
          m_data_d = NOP_VAL;
          s_data_d = NOP_VAL;
        end
      endcase
    end
  end

  // Handshake outputs decoded from the registered state and the stall/flush inputs.
  always_comb begin
    m_valid   = (state_q == ONE) || (state_q == FULL);
    s_valid   = (state_q == FULL);
    out_valid = m_valid && !stall;
    out_data  = m_data_q;
    in_ready  = !s_valid && !stall && !flush;
    acc       = in_valid && in_ready;
    pop       = out_valid && out_ready;
    occupancy = {1'b0, m_valid} + {1'b0, s_valid};
  end

`ifdef SEG_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, xfer_cnt_q;

  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (pop && (xfer_cnt_q != '1))    xfer_cnt_q  <= xfer_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign xfer_cnt  = xfer_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign xfer_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_seg_reg_hs.sv
// Directed, table-driven bench for pipe_seg_reg_hs. Two instances share the
// stimulus: a 32-bit one with 32-bit counters and an 8-bit one with 2-bit
// counters, which exercises counter saturation.
module tb_pipe_seg_reg_hs;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        st;
    logic        fl;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_od;
    logic [1:0]  e_occ;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [31:0] stall_cnt, flush_cnt, xfer_cnt;

  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_data;
  logic [1:0]  s_occupancy;
  logic [1:0]  s_stall_cnt, s_flush_cnt, s_xfer_cnt;

  int checks = 0;
  int errors = 0;
  vec_t tbl_a[$];
  vec_t tbl_b[$];

  always #5 clk = ~clk;

  pipe_seg_reg_hs #(.DW(32), .NOP_VAL(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall(stall), .flush(flush), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .xfer_cnt(xfer_cnt)
  );

  pipe_seg_reg_hs #(.DW(8), .NOP_VAL(8'h0), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data[7:0]),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .stall(stall), .flush(flush), .occupancy(s_occupancy),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .xfer_cnt(s_xfer_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                              input logic st, input logic fl, input logic e_ov,
                              input logic e_ir, input logic [31:0] e_od, input logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.st = st; v.fl = fl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_od = e_od; v.e_occ = e_occ;
    return v;
  endfunction

  // Drive one vector (called at posedge+1), check outputs mid-cycle, then advance one edge.
  task automatic apply(input vec_t v, input int idx);
    string tag;
    in_valid = v.iv; in_data = v.d; out_ready = v.ordy; stall = v.st; flush = v.fl;
    #1;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, v.e_ov});
    chk({tag, ".in_ready"},  {31'b0, in_ready},  {31'b0, v.e_ir});
    chk({tag, ".out_data"},  out_data,           v.e_od);
    chk({tag, ".occupancy"}, {30'b0, occupancy}, {30'b0, v.e_occ});
    chk({tag, ".s_out_valid"}, {31'b0, s_out_valid}, {31'b0, v.e_ov});
    chk({tag, ".s_in_ready"},  {31'b0, s_in_ready},  {31'b0, v.e_ir});
    chk({tag, ".s_out_data"},  {24'b0, s_out_data},  {24'b0, v.e_od[7:0]});
    chk({tag, ".s_occupancy"}, {30'b0, s_occupancy}, {30'b0, v.e_occ});
    @(posedge clk); #1;
  endtask

  initial begin
    //                iv d      ordy st fl   ov ir od     occ
    // streaming 1..4
    tbl_a.push_back(mk(1, 32'd1,  1, 0, 0,  0, 1, 32'd0,  2'd0));
    tbl_a.push_back(mk(1, 32'd2,  1, 0, 0,  1, 1, 32'd1,  2'd1));
    tbl_a.push_back(mk(1, 32'd3,  1, 0, 0,  1, 1, 32'd2,  2'd1));
    tbl_a.push_back(mk(1, 32'd4,  1, 0, 0,  1, 1, 32'd3,  2'd1));
    tbl_a.push_back(mk(0, 32'd0,  1, 0, 0,  1, 1, 32'd4,  2'd1));
    tbl_a.push_back(mk(0, 32'd0,  0, 0, 0,  0, 1, 32'd0,  2'd0));
    // backpressure 10,11,12
    tbl_a.push_back(mk(1, 32'd10, 0, 0, 0,  0, 1, 32'd0,  2'd0));
    tbl_a.push_back(mk(1, 32'd11, 0, 0, 0,  1, 1, 32'd10, 2'd1));
    tbl_a.push_back(mk(1, 32'd12, 0, 0, 0,  1, 0, 32'd10, 2'd2));
    tbl_a.push_back(mk(1, 32'd12, 1, 0, 0,  1, 0, 32'd10, 2'd2));
    tbl_a.push_back(mk(1, 32'd12, 1, 0, 0,  1, 1, 32'd11, 2'd1));
    tbl_a.push_back(mk(0, 32'd0,  1, 0, 0,  1, 1, 32'd12, 2'd1));
    tbl_a.push_back(mk(0, 32'd0,  0, 0, 0,  0, 1, 32'd0,  2'd0));
    // stall while FULL with 5,6
    tbl_a.push_back(mk(1, 32'd5,  0, 0, 0,  0, 1, 32'd0,  2'd0));
    tbl_a.push_back(mk(1, 32'd6,  0, 0, 0,  1, 1, 32'd5,  2'd1));
    tbl_a.push_back(mk(1, 32'd99, 1, 1, 0,  0, 0, 32'd5,  2'd2));
    tbl_a.push_back(mk(1, 32'd99, 1, 1, 0,  0, 0, 32'd5,  2'd2));
    tbl_a.push_back(mk(1, 32'd99, 1, 1, 0,  0, 0, 32'd5,  2'd2));
    tbl_a.push_back(mk(0, 32'd0,  1, 0, 0,  1, 0, 32'd5,  2'd2));
    tbl_a.push_back(mk(0, 32'd0,  1, 0, 0,  1, 1, 32'd6,  2'd1));
    tbl_a.push_back(mk(0, 32'd0,  0, 0, 0,  0, 1, 32'd0,  2'd0));
    // flush together with stall while FULL with 7,8
    tbl_a.push_back(mk(1, 32'd7,  0, 0, 0,  0, 1, 32'd0,  2'd0));
    tbl_a.push_back(mk(1, 32'd8,  0, 0, 0,  1, 1, 32'd7,  2'd1));
    tbl_a.push_back(mk(1, 32'd9,  1, 1, 1,  0, 0, 32'd7,  2'd2));
    tbl_a.push_back(mk(0, 32'd0,  1, 0, 0,  0, 1, 32'd0,  2'd0));
    tbl_a.push_back(mk(0, 32'd0,  1, 0, 0,  0, 1, 32'd0,  2'd0));
    // flush coinciding with a pop: 30 is delivered, 31 is refused
    tbl_a.push_back(mk(1, 32'd30, 0, 0, 0,  0, 1, 32'd0,  2'd0));
    tbl_a.push_back(mk(1, 32'd31, 1, 0, 1,  1, 0, 32'd30, 2'd1));
    tbl_a.push_back(mk(0, 32'd0,  0, 0, 0,  0, 1, 32'd0,  2'd0));
    // flush held high for two cycles keeps the stage empty
    tbl_a.push_back(mk(1, 32'd40, 1, 0, 1,  0, 0, 32'd0,  2'd0));
    tbl_a.push_back(mk(1, 32'd41, 1, 0, 1,  0, 0, 32'd0,  2'd0));
    tbl_a.push_back(mk(0, 32'd0,  0, 0, 0,  0, 1, 32'd0,  2'd0));
    // fresh stream after asynchronous reset
    tbl_b.push_back(mk(1, 32'd20, 1, 0, 0,  0, 1, 32'd0,  2'd0));
    tbl_b.push_back(mk(1, 32'd21, 1, 0, 0,  1, 1, 32'd20, 2'd1));
    tbl_b.push_back(mk(0, 32'd0,  1, 0, 0,  1, 1, 32'd21, 2'd1));
    tbl_b.push_back(mk(0, 32'd0,  0, 0, 0,  0, 1, 32'd0,  2'd0));

    // Reset state, checked while rst_n is still low
    #12;
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.out_data", out_data, 32'd0);
    chk("rst.occupancy", {30'b0, occupancy}, 32'd0);
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst.xfer_cnt", xfer_cnt, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl_a[i]) apply(tbl_a[i], i);

    // Totals: 10 pops, 4 stall cycles, 4 flush cycles
`ifdef SEG_PERF_CNT_EN
    chk("cnt.xfer", xfer_cnt, 32'd10);
    chk("cnt.stall", stall_cnt, 32'd4);
    chk("cnt.flush", flush_cnt, 32'd4);
    chk("cnt.s_xfer_sat", {30'b0, s_xfer_cnt}, 32'd3);
    chk("cnt.s_stall_sat", {30'b0, s_stall_cnt}, 32'd3);
    chk("cnt.s_flush_sat", {30'b0, s_flush_cnt}, 32'd3);
`else
    chk("cnt.xfer_off", xfer_cnt, 32'd0);
    chk("cnt.stall_off", stall_cnt, 32'd0);
    chk("cnt.flush_off", flush_cnt, 32'd0);
    chk("cnt.s_xfer_off", {30'b0, s_xfer_cnt}, 32'd0);
    chk("cnt.s_stall_off", {30'b0, s_stall_cnt}, 32'd0);
    chk("cnt.s_flush_off", {30'b0, s_flush_cnt}, 32'd0);
`endif

    // Fill to FULL with 50,51, then assert reset between edges
    in_valid = 1; in_data = 32'd50; out_ready = 0; stall = 0; flush = 0;
    @(posedge clk); #1;
    in_data = 32'd51;
    @(posedge clk); #1;
    in_valid = 0;
    #1;
    chk("pre_rst.occupancy", {30'b0, occupancy}, 32'd2);
    chk("pre_rst.out_data", out_data, 32'd50);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst.out_data", out_data, 32'd0);
    chk("arst.occupancy", {30'b0, occupancy}, 32'd0);
    chk("arst.in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst.xfer_cnt", xfer_cnt, 32'd0);
    chk("arst.stall_cnt", stall_cnt, 32'd0);
    chk("arst.s_xfer_cnt", {30'b0, s_xfer_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl_b[i]) apply(tbl_b[i], 100 + i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
